// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - restoring divider shared by two requesters under round-robin arbitration
// One operation at a time; results hold until the next completion.
module div_share_ctrl #(
    parameter int SIZE = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic [SIZE-1:0] x0,
    input  logic [SIZE-1:0] y0,
    input  logic            req1,
    input  logic [SIZE-1:0] x1,
    input  logic [SIZE-1:0] y1,
    output logic [SIZE-1:0] q,
    output logic [SIZE-1:0] r,
    output logic            error,
    output logic            done0,
    output logic            done1,
    output logic            busy
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic            prio;
    logic            owner;
    logic [SIZE-1:0] dvd;
    logic [SIZE-1:0] dvs;
    logic [SIZE-1:0] quo;
    logic [SIZE:0]   rem;
    logic [CW-1:0]   cnt;

    logic            grant_any;
    logic            grant_ch;
    logic [SIZE:0]   rem_sh;
    logic            fits;
    logic [SIZE:0]   rem_nx;
    logic [SIZE-1:0] quo_nx;
    logic            div_zero;
    logic            last_step;

    always_comb begin
        grant_any = req0 | req1;
        grant_ch  = req1 & (~req0 | prio);
        rem_sh    = {rem[SIZE-1:0], dvd[SIZE-1]};
        fits      = (rem_sh >= {1'b0, dvs});
        rem_nx    = fits ? (rem_sh - {1'b0, dvs}) : rem_sh;
        quo_nx    = {quo[SIZE-2:0], fits};
        div_zero  = (dvs == '0);
        last_step = (cnt == CW'(1));
    end

    // A zero divisor spends its single RUN cycle detecting the case, so its
    // completion pulse lands one cycle after the accept edge.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (grant_any) state_n = RUN;
            RUN:     if (div_zero || last_step) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            owner <= 1'b0;
            dvd   <= '0;
            dvs   <= '0;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            error <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner <= grant_ch;
                        prio  <= ~grant_ch;
                        dvd   <= grant_ch ? x1 : x0;
                        dvs   <= grant_ch ? y1 : y0;
                        rem   <= '0;
                        quo   <= '0;
                        cnt   <= CW'(SIZE);
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (div_zero) begin
                        q     <= '1;
                        r     <= dvd;
                        error <= 1'b1;
                        done0 <= ~owner;
                        done1 <= owner;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        dvd <= dvd << 1;
                        cnt <= cnt - CW'(1);
                        if (last_step) begin
                            q     <= quo_nx;
                            r     <= rem_nx[SIZE-1:0];
                            error <= 1'b0;
                            done0 <= ~owner;
                            done1 <= owner;
                        end
                    end
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb/tb_div_share_ctrl.sv - self-checking bench for div_share_ctrl
module tb_div_share_ctrl;

    localparam int SIZE = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req0 = 1'b0;
    logic            req1 = 1'b0;
    logic [SIZE-1:0] x0 = '0;
    logic [SIZE-1:0] y0 = '0;
    logic [SIZE-1:0] x1 = '0;
    logic [SIZE-1:0] y1 = '0;
    logic [SIZE-1:0] q;
    logic [SIZE-1:0] r;
    logic            error;
    logic            done0;
    logic            done1;
    logic            busy;

    int errors = 0;
    int checks = 0;

    div_share_ctrl #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .x0    (x0),
        .y0    (y0),
        .req1  (req1),
        .x1    (x1),
        .y1    (y1),
        .q     (q),
        .r     (r),
        .error (error),
        .done0 (done0),
        .done1 (done1),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input int x, input int y);
        int eq, er, ee;
        if (y == 0) begin
            eq = (1 << SIZE) - 1;
            er = x;
            ee = 1;
        end else begin
            eq = x / y;
            er = x % y;
            ee = 0;
        end
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".r"}, 32'(r), 32'(er));
        chk({tag, ".error"}, 32'(error), 32'(ee));
    endtask

    task automatic wait_done(input string tag, output int ch, output int lat);
        ch  = -1;
        lat = 0;
        while (ch < 0 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (done0 && done1) chk({tag, ".both_done"}, 32'd1, 32'd0);
            if (done0) ch = 0;
            else if (done1) ch = 1;
        end
        if (ch < 0) chk({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_single(input string tag, input int ch, input int x, input int y);
        int gch, lat;
        @(negedge clk);
        if (ch == 0) begin
            x0 = SIZE'(x); y0 = SIZE'(y); req0 = 1'b1;
        end else begin
            x1 = SIZE'(x); y1 = SIZE'(y); req1 = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, ".busy_accept"}, 32'(busy), 32'd1);
        // operands after the accept edge must be ignored
        x0 = ~x0; y0 = ~y0; x1 = ~x1; y1 = ~y1;
        wait_done(tag, gch, lat);
        chk({tag, ".chan"}, 32'(gch), 32'(ch));
        chk({tag, ".latency"}, 32'(lat), (y == 0) ? 32'd1 : 32'(SIZE));
        check_result(tag, x, y);
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ch, lat;
        int ex [2];
        int ey [2];
        bit seen;

        // reset state
        #2;
        chk("reset.q", 32'(q), 32'd0);
        chk("reset.r", 32'(r), 32'd0);
        chk("reset.error", 32'(error), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'({done0, done1}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_single("t1", 0, 23, 5);
        run_single("t2", 1, 17, 0);

        // simultaneous requests after reset
        do_reset();
        @(negedge clk);
        x0 = 5'd31; y0 = 5'd1; x1 = 5'd7; y1 = 5'd9;
        req0 = 1'b1; req1 = 1'b1;
        @(posedge clk);
        #1;
        wait_done("t3a", ch, lat);
        chk("t3a.chan", 32'(ch), 32'd0);
        chk("t3a.latency", 32'(lat), 32'(SIZE));
        check_result("t3a", 31, 1);
        req0 = 1'b0;
        wait_done("t3b", ch, lat);
        chk("t3b.chan", 32'(ch), 32'd1);
        chk("t3b.gap", 32'(lat), 32'(SIZE + 2));
        check_result("t3b", 7, 9);
        req1 = 1'b0;

        // both held high: grants alternate
        do_reset();
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            ex[c] = $urandom_range(0, 31);
            ey[c] = $urandom_range(0, 31);
        end
        x0 = SIZE'(ex[0]); y0 = SIZE'(ey[0]);
        x1 = SIZE'(ex[1]); y1 = SIZE'(ey[1]);
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_done("t4", ch, lat);
            chk($sformatf("t4.chan%0d", i), 32'(ch), 32'(i % 2));
            if (ch >= 0) begin
                check_result($sformatf("t4.op%0d", i), ex[ch], ey[ch]);
                ex[ch] = $urandom_range(0, 31);
                ey[ch] = (i == 2) ? 0 : $urandom_range(0, 31);
                if (ch == 0) begin x0 = SIZE'(ex[0]); y0 = SIZE'(ey[0]); end
                else begin x1 = SIZE'(ex[1]); y1 = SIZE'(ey[1]); end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk);
        #1;

        // boundaries
        run_single("t6a", 0, 31, 31);
        run_single("t6b", 1, 0, 7);
        run_single("t6c", 0, 30, 31);
        run_single("t6d", 1, 31, 30);

        // random single operations
        for (int i = 0; i < 16; i++) begin
            run_single($sformatf("rnd%0d", i), int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        end

        // reset during RUN aborts the operation
        run_single("t5pre", 0, 31, 30);
        @(negedge clk);
        x0 = 5'd23; y0 = 5'd5; req0 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req0 = 1'b0;
        #1;
        chk("t5.q", 32'(q), 32'd0);
        chk("t5.r", 32'(r), 32'd0);
        chk("t5.error", 32'(error), 32'd0);
        chk("t5.busy", 32'(busy), 32'd0);
        chk("t5.done", 32'({done0, done1}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done0 || done1 || busy) seen = 1'b1;
        end
        chk("t5.no_done", 32'(seen), 32'd0);
        run_single("t5post", 0, 3, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
